param_stack: RTL and testbench

- Parametrised LIFO register stack; next generation of the CPU register-backup stack.
- Configurable width and depth.
- Adds full/empty/count status, safe overflow and underflow handling with sticky error flags and an interrupt pulse, and a defined simultaneous push+pop (replace-top) operation.
- Sits beside the CPU register file; driven by the push/pop stage controls and the pipeline clear/hold signals.

---
 rtl/param_stack.sv | 126 ++++++++++++
 tb/tb_param_stack.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO register-backup stack.
// Tracks fill level, flags overflow/underflow (sticky) with a one-cycle
// interrupt pulse, and supports push+pop in one cycle as replace-top.
//
// Request semantics: push and pop are single-cycle requests sampled on every
// rising clk edge; there is no back-pressure. A request the stack cannot
// honour (push when full, effective pop when empty) is refused safely and
// reported through overflow/underflow and intr. pop is qualified by clear
// (priority) and hold; push is never qualified.
module param_stack #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     q,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    input  logic                 hold,
    input  logic                 err_clr,
    output logic [ADDR_BITS:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 intr
);

    localparam int                  DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]  FULL_CNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]  ONE_P    = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] ONE_A   = ADDR_BITS'(1);

    // Storage: one write port, one registered read port (block RAM friendly).
    logic [WIDTH-1:0] mem [DEPTH];

    // ptr counts valid entries; it also addresses the next free slot.
    logic [ADDR_BITS:0]   ptr;
    logic [ADDR_BITS-1:0] top_addr;
    logic [ADDR_BITS-1:0] wr_addr;
    logic                 is_empty;
    logic                 is_full;
    logic                 pop_clr;
    logic                 epop;
    logic                 under_ev;
    logic                 over_ev;
    logic                 wr_en;
    logic                 ptr_inc;
    logic                 ptr_dec;

    assign is_empty = (ptr == '0);
    assign is_full  = (ptr == FULL_CNT);
    assign top_addr = ptr[ADDR_BITS-1:0] - ONE_A;

    assign count = ptr;
    assign empty = is_empty;
    assign full  = is_full;

    // Decode the operation for this cycle from the qualified requests.
    always_comb begin
        pop_clr  = pop & clear;
        epop     = pop & ~clear & ~hold;
        under_ev = epop & is_empty;
        // push alongside an effective pop never overflows (replace-top or
        // push into an empty stack after the underflow).
        over_ev  = push & ~epop & is_full;
        wr_en    = push & (epop | ~is_full);
        // Replace-top overwrites the current top; otherwise write the free slot.
        wr_addr  = (epop & ~is_empty) ? top_addr : ptr[ADDR_BITS-1:0];
        ptr_inc  = push & ((epop & is_empty) | (~epop & ~is_full));
        ptr_dec  = epop & ~push & ~is_empty;
    end

    // Memory write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= d;
        end
    end

    // Registered pop result: reads the old top, so replace-top needs no bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (pop_clr) begin
            q <= '0;
        end else if (epop) begin
            q <= is_empty ? '0 : mem[top_addr];
        end
    end

    // Fill-level pointer, saturating at 0 and DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (ptr_inc) begin
            ptr <= ptr + ONE_P;
        end else if (ptr_dec) begin
            ptr <= ptr - ONE_P;
        end
    end

    // Sticky error flags (a new event beats err_clr) and one-cycle interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            intr      <= 1'b0;
        end else begin
            intr <= over_ev | under_ev;
            if (over_ev) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (under_ev) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed + short random test of param_stack (ADDR_BITS=3).
module tb_param_stack;

    localparam int W       = 32;
    localparam int AB      = 3;
    localparam int DEPTH_T = 8;

    logic          clk;
    logic          reset;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic          push;
    logic          pop;
    logic          clear;
    logic          hold;
    logic          err_clr;
    logic [AB:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic          intr;

    int checks   = 0;
    int failures = 0;

    // Scoreboard and reference model state.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_stack[$];
    logic [W-1:0] m_q;
    logic         m_ov;
    logic         m_un;
    logic         m_intr;

    param_stack #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .q         (q),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .hold      (hold),
        .err_clr   (err_clr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .intr      (intr)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stack.delete();
        exp_q.delete();
        m_q    = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
        m_intr = 1'b0;
    endtask

    task automatic do_reset();
        push = 0; pop = 0; clear = 0; hold = 0; err_clr = 0; d = '0;
        reset = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Driver: applies one cycle of inputs, updates the model, then checks outputs.
    task automatic cycle(input string tag, input logic p, input logic po, input logic cl,
                         input logic ho, input logic ec, input logic [W-1:0] dv);
        logic         ep;
        logic         ev_un;
        logic         ev_ov;
        logic [W-1:0] nq;
        int           sz;
        push = p; pop = po; clear = cl; hold = ho; err_clr = ec; d = dv;
        sz    = m_stack.size();
        ep    = po & ~cl & ~ho;
        ev_un = ep && (sz == 0);
        ev_ov = p && !ep && (sz == DEPTH_T);
        nq    = m_q;
        if (po && cl)  nq = '0;
        else if (ep)   nq = (sz != 0) ? m_stack[sz-1] : '0;
        if (ep && p) begin
            if (sz != 0) m_stack[sz-1] = dv;
            else         m_stack.push_back(dv);
        end else if (ep) begin
            if (sz != 0) void'(m_stack.pop_back());
        end else if (p && sz < DEPTH_T) begin
            m_stack.push_back(dv);
        end
        m_ov   = ev_ov | (m_ov & ~ec);
        m_un   = ev_un | (m_un & ~ec);
        m_intr = ev_ov | ev_un;
        if (po) exp_q.push_back(nq);
        m_q = nq;
        @(posedge clk); #1;
        push = 0; pop = 0; clear = 0; hold = 0; err_clr = 0;
        if (po && exp_q.size() != 0) check({tag, "_q"}, q, exp_q.pop_front());
        else                         check({tag, "_q_stable"}, q, m_q);
        check({tag, "_count"}, W'(count), W'(m_stack.size()));
        check({tag, "_empty"}, W'(empty), W'(m_stack.size() == 0));
        check({tag, "_full"},  W'(full),  W'(m_stack.size() == DEPTH_T));
        check({tag, "_ovf"},   W'(overflow),  W'(m_ov));
        check({tag, "_unf"},   W'(underflow), W'(m_un));
        check({tag, "_intr"},  W'(intr),      W'(m_intr));
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        check("rst_count", W'(count), 0);
        check("rst_q", q, 0);
        check("rst_empty", W'(empty), 1);
        check("rst_ovf", W'(overflow), 0);
        check("rst_intr", W'(intr), 0);

        // Basic LIFO order.
        cycle("p11", 1, 0, 0, 0, 0, 32'h11);
        cycle("p22", 1, 0, 0, 0, 0, 32'h22);
        cycle("p33", 1, 0, 0, 0, 0, 32'h33);
        check("lifo_count3", W'(count), 3);
        cycle("pop1", 0, 1, 0, 0, 0, 0);
        check("lifo_q33", q, 32'h33);
        cycle("pop2", 0, 1, 0, 0, 0, 0);
        check("lifo_q22", q, 32'h22);
        cycle("pop3", 0, 1, 0, 0, 0, 0);
        check("lifo_q11", q, 32'h11);
        check("lifo_empty", W'(empty), 1);
        check("lifo_nointr", W'(intr), 0);

        // Fill to full and overflow.
        for (int i = 1; i <= 8; i++) cycle("fill", 1, 0, 0, 0, 0, W'(i));
        check("fill_full", W'(full), 1);
        cycle("ovf_push", 1, 0, 0, 0, 0, 32'h9);
        check("ovf_flag", W'(overflow), 1);
        check("ovf_intr", W'(intr), 1);
        check("ovf_count", W'(count), 8);
        cycle("ovf_idle", 0, 0, 0, 0, 0, 0);
        check("ovf_intr_drop", W'(intr), 0);
        for (int i = 8; i >= 1; i--) begin
            cycle("drain", 0, 1, 0, 0, 0, 0);
            check("drain_val", q, W'(i));
        end

        // Underflow, err_clr, and set-beats-clear.
        cycle("unf_pop", 0, 1, 0, 0, 0, 0);
        check("unf_q", q, 0);
        check("unf_flag", W'(underflow), 1);
        check("unf_intr", W'(intr), 1);
        cycle("unf_idle", 0, 0, 0, 0, 0, 0);
        check("unf_intr_drop", W'(intr), 0);
        cycle("errclr", 0, 0, 0, 0, 1, 0);
        check("errclr_unf", W'(underflow), 0);
        check("errclr_ovf", W'(overflow), 0);
        cycle("errclr_set", 0, 1, 0, 0, 1, 0);
        check("set_wins", W'(underflow), 1);
        cycle("unf_b2b", 0, 1, 0, 0, 0, 0);
        check("b2b_intr", W'(intr), 1);
        cycle("errclr2", 0, 0, 0, 0, 1, 0);

        // Replace-top.
        cycle("pA", 1, 0, 0, 0, 0, 32'hA);
        cycle("pB", 1, 0, 0, 0, 0, 32'hB);
        cycle("repl", 1, 1, 0, 0, 0, 32'hC);
        check("repl_q", q, 32'hB);
        check("repl_count", W'(count), 2);
        cycle("repl_pop", 0, 1, 0, 0, 0, 0);
        check("repl_top", q, 32'hC);

        // clear / hold qualification.
        cycle("pD", 1, 0, 0, 0, 0, 32'hD);
        cycle("hold", 0, 1, 0, 1, 0, 0);
        check("hold_q", q, 32'hC);
        check("hold_count", W'(count), 2);
        cycle("clr", 0, 1, 1, 0, 0, 0);
        check("clr_q", q, 0);
        check("clr_count", W'(count), 2);
        cycle("repl2", 1, 1, 0, 0, 0, 32'hF);
        check("repl2_q", q, 32'hD);
        cycle("clrhold", 0, 1, 1, 1, 0, 0);
        check("clrhold_q", q, 0);
        cycle("clr_push", 1, 1, 1, 0, 0, 32'h6);
        check("clr_push_count", W'(count), 3);

        // Replace-top when full does not overflow.
        for (int i = 0; i < 5; i++) cycle("fill2", 1, 0, 0, 0, 0, W'(32'h40 + i));
        cycle("repl_full", 1, 1, 0, 0, 0, 32'h77);
        check("repl_full_q", q, 32'h44);
        check("repl_full_ovf", W'(overflow), 0);
        check("repl_full_count", W'(count), 8);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 9) == 0), W'($urandom_range(0, 32'hFFFF)));
        end

        // Push+pop on empty: underflow, then the push lands.
        for (int i = 0; i < 9; i++) cycle("drain2", 0, 1, 0, 0, 0, 0);
        cycle("errclr3", 0, 0, 0, 0, 1, 0);
        cycle("pp_empty", 1, 1, 0, 0, 0, 32'h5A);
        check("pp_empty_q", q, 0);
        check("pp_empty_unf", W'(underflow), 1);
        check("pp_empty_count", W'(count), 1);
        cycle("pp_empty_pop", 0, 1, 0, 0, 0, 0);
        check("pp_empty_val", q, 32'h5A);

        // Asynchronous reset mid-cycle with count=5.
        do_reset();
        for (int i = 1; i <= 6; i++) cycle("pre_ar", 1, 0, 0, 0, 0, W'(32'h60 + i));
        cycle("pre_ar_pop", 0, 1, 0, 0, 0, 0);
        check("pre_ar_q", q, 32'h66);
        check("pre_ar_count", W'(count), 5);
        #2 reset = 1'b1;
        #1;
        check("ar_count", W'(count), 0);
        check("ar_q", q, 0);
        check("ar_empty", W'(empty), 1);
        #2 reset = 1'b0;
        model_reset();
        cycle("ar_unf", 0, 1, 0, 0, 0, 0);
        check("ar_unf_flag", W'(underflow), 1);
        check("ar_unf_intr", W'(intr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
